// File: rtl/cdc_rx_buffer.sv
// Receive-side elastic buffer: absorbs a free-running valid/data stream and re-presents it as valid/ready.
// Latency: a push reaches o_data one cycle later; the source cannot be stalled, so pushes into a full buffer are dropped and counted.
module cdc_rx_buffer #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 32,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                       i_clk,
    input  logic                       i_clk_rst,
    input  logic                       i_data_vld,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_data_vld,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_data_rdy,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_afull,
    output logic                       o_overflow,
    output logic [15:0]                o_drop_count,
    input  logic                       i_clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             full, push, pop, drop;

    assign full       = (level_q == FULL_LVL);
    assign o_data_vld = (level_q != '0);
    assign pop        = o_data_vld & i_data_rdy;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign push       = i_data_vld & (~full | pop);
    assign drop       = i_data_vld & full & ~pop;

    assign o_data       = mem_q[rd_ptr_q];
    assign o_level      = level_q;
    assign o_afull      = (level_q >= AFULL_LVL);
    assign o_overflow   = ovf_q;
    assign o_drop_count = drop_cnt_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // A drop coinciding with a clear must survive the clear.
        if (i_clr_overflow) begin
            ovf_d      = drop;
            drop_cnt_d = {15'd0, drop};
        end else if (drop) begin
            ovf_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_clk_rst && push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule

// File: tb/tb_cdc_rx_buffer.sv
// Scoreboard bench for cdc_rx_buffer: a queue model predicts accepted words, occupancy and drop accounting.
module tb_cdc_rx_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int AFULL = DEPTH - 4;

    logic             clk;
    logic             rst;
    logic             vld;
    logic [WIDTH-1:0] din;
    logic             rdy;
    logic             clr;
    logic             o_vld;
    logic [WIDTH-1:0] o_dat;
    logic [4:0]       o_level;
    logic             o_afull;
    logic             o_ovf;
    logic [15:0]      o_cnt;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb[$];
    int               mlevel = 0;
    logic             movf   = 1'b0;
    int               mcnt   = 0;
    bit               mon_en = 1'b0;

    cdc_rx_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_LEVEL(AFULL)) dut (
        .i_clk          (clk),
        .i_clk_rst      (rst),
        .i_data_vld     (vld),
        .i_data         (din),
        .o_data_vld     (o_vld),
        .o_data         (o_dat),
        .i_data_rdy     (rdy),
        .o_level        (o_level),
        .o_afull        (o_afull),
        .o_overflow     (o_ovf),
        .o_drop_count   (o_cnt),
        .i_clr_overflow (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model across the clock edge.
    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit y, input bit c);
        bit mpop, mpush, mdrop;
        rst = r; vld = v; din = d; rdy = y; clr = c;
        @(posedge clk);
        if (r) begin
            mlevel = 0;
            sb.delete();
            movf = 1'b0;
            mcnt = 0;
        end else begin
            mpop  = (mlevel > 0) && y;
            mpush = v && ((mlevel < DEPTH) || mpop);
            mdrop = v && (mlevel == DEPTH) && !mpop;
            if (mpush) sb.push_back(d);
            mlevel = mlevel + int'(mpush) - int'(mpop);
            if (c) begin
                movf = mdrop;
                mcnt = int'(mdrop);
            end else if (mdrop) begin
                movf = 1'b1;
                if (mcnt < 16'hFFFF) mcnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit y);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, y, 1'b0);
    endtask

    // Monitor: sampled mid-cycle, compares the presented head word and status against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("vld", {31'd0, o_vld}, {31'd0, (mlevel != 0)});
            chk("level", {27'd0, o_level}, mlevel);
            chk("afull", {31'd0, o_afull}, {31'd0, (mlevel >= AFULL)});
            chk("overflow", {31'd0, o_ovf}, {31'd0, movf});
            chk("drop_count", {16'd0, o_cnt}, mcnt);
            if (o_vld) begin
                if (sb.size() == 0) begin
                    chk("data_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("data", o_dat, sb[0]);
                    if (rdy) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; vld = 1'b0; din = '0; rdy = 1'b0; clr = 1'b0;
        step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        mon_en = 1'b1;
        chk("reset_level", {27'd0, o_level}, 32'd0);
        chk("reset_vld", {31'd0, o_vld}, 32'd0);

        // Streaming with consumer always ready.
        step(1'b0, 1'b1, 32'h11, 1'b1, 1'b0);
        chk("first_word", o_dat, 32'h11);
        step(1'b0, 1'b1, 32'h22, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h33, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Fill with consumer stalled.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, i, 1'b0, 1'b0);
        chk("full_level", {27'd0, o_level}, 32'd16);
        chk("full_afull", {31'd0, o_afull}, 32'd1);
        chk("full_head", o_dat, 32'd0);
        chk("full_no_ovf", {31'd0, o_ovf}, 32'd0);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100 + i, 1'b0, 1'b0);
        chk("drop_ovf", {31'd0, o_ovf}, 32'd1);
        chk("drop_cnt3", {16'd0, o_cnt}, 32'd3);
        idle(DEPTH + 2, 1'b1);
        chk("drained", {27'd0, o_level}, 32'd0);

        // Full with simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h200 + i, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h2FF, 1'b1, 1'b0);
        chk("full_pushpop_level", {27'd0, o_level}, 32'd16);
        chk("full_pushpop_nodrop", {16'd0, o_cnt}, 32'd3);
        idle(DEPTH + 2, 1'b1);

        // Clear behaviour, including clear coinciding with a drop.
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_cnt", {16'd0, o_cnt}, 32'd0);
        for (int i = 0; i < DEPTH + 5; i++) step(1'b0, 1'b1, 32'h300 + i, 1'b0, 1'b0);
        chk("drop_cnt5", {16'd0, o_cnt}, 32'd5);
        step(1'b0, 1'b1, 32'h3FF, 1'b0, 1'b1);
        chk("clr_drop_ovf", {31'd0, o_ovf}, 32'd1);
        chk("clr_drop_cnt", {16'd0, o_cnt}, 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("clr_alone_ovf", {31'd0, o_ovf}, 32'd0);
        chk("clr_alone_cnt", {16'd0, o_cnt}, 32'd0);
        chk("clr_keeps_level", {27'd0, o_level}, 32'd16);

        // Reset mid-operation with 7 words stored.
        idle(9, 1'b1);
        chk("seven_left", {27'd0, o_level}, 32'd7);
        step(1'b1, 1'b1, 32'h55, 1'b1, 1'b0);
        chk("midrst_vld", {31'd0, o_vld}, 32'd0);
        chk("midrst_level", {27'd0, o_level}, 32'd0);
        step(1'b0, 1'b1, 32'hAB, 1'b0, 1'b0);
        chk("post_rst_head", o_dat, 32'hAB);
        idle(2, 1'b1);

        // Randomized traffic in phases of differing consumer pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 95);
            for (int i = 0; i < 600; i++) begin
                step($urandom_range(999) < 3,
                     $urandom_range(99) < 70,
                     $urandom,
                     $urandom_range(99) < rdy_pct,
                     $urandom_range(99) < 2);
            end
        end
        idle(DEPTH + 2, 1'b1);
        chk("final_empty", {27'd0, o_level}, 32'd0);
        chk("final_sb_empty", sb.size(), 32'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdc_rx_buffer.md
CDC_RX_BUFFER -- requirements
Module: cdc_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, storage entries; power of 2 and at least 4.
REQ-002 SHALL have parameter WIDTH, default 32, data word width.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-4, o_afull threshold in entries.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all logic on the rising edge.
REQ-005 SHALL have port i_clk_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_data_vld, input, 1: input word valid; no backpressure to the source.
REQ-007 SHALL have port i_data, input, WIDTH: input word.
REQ-008 SHALL have port o_data_vld, output, 1: head word valid.
REQ-009 SHALL have port o_data, output, WIDTH: head word.
REQ-010 SHALL have port i_data_rdy, input, 1: consumer accepts the head word.
REQ-011 SHALL have port o_level, output, $clog2(DEPTH)+1: current entry count.
REQ-012 SHALL have port o_afull, output, 1: o_level >= AFULL_LEVEL.
REQ-013 SHALL have port o_overflow, output, 1: sticky flag, set when a word is dropped.
REQ-014 SHALL have port o_drop_count, output, 16: saturating count of dropped words.
REQ-015 SHALL have port i_clr_overflow, input, 1: clears o_overflow and o_drop_count.

Function
REQ-016 SHALL act as the consumer end of a non-flow-controlled CDC FIFO read port: it absorbs a free-running valid/data stream and re-presents it as a valid/ready stream.
REQ-017 Push SHALL occur when i_data_vld=1 and (o_level<DEPTH or pop in the same cycle).
REQ-018 Pop SHALL occur when o_data_vld=1 and i_data_rdy=1.
REQ-019 o_data_vld SHALL equal (o_level!=0), registered; there SHALL be no same-cycle bypass.
REQ-020 A word pushed in cycle N SHALL appear on o_data no earlier than cycle N+1, and at N+1 when the buffer was empty.
REQ-021 o_data SHALL always be the oldest stored word.
REQ-022 o_data and o_data_vld SHALL hold stable while o_data_vld=1 and i_data_rdy=0.
REQ-023 o_data SHALL be don't-care while o_data_vld=0.
REQ-024 Order SHALL be strict FIFO; write and read pointers SHALL wrap modulo DEPTH.
REQ-025 o_level SHALL update as level + push - pop, registered, and stay within 0..DEPTH.
REQ-026 Full with simultaneous push and pop SHALL leave o_level at DEPTH and accept the new word.
REQ-027 o_afull SHALL be derived from the registered o_level, with no added latency relative to it.
REQ-028 A drop SHALL occur when i_data_vld=1, o_level=DEPTH and no pop in that cycle; the word SHALL be discarded and stored contents left intact.
REQ-029 A drop SHALL set o_overflow in the following cycle and increment o_drop_count, saturating at 0xFFFF.
REQ-030 i_clr_overflow=1 SHALL clear o_overflow to 0 and o_drop_count to 0 next cycle.
REQ-031 A clear and a drop in the same cycle SHALL give o_overflow=1 and o_drop_count=1, so the new drop is not lost.
REQ-032 i_clr_overflow SHALL NOT affect stored data, pointers or o_level.

Reset
REQ-033 While i_clk_rst=1 (sampled at the clock edge): pointers=0, o_level=0, o_data_vld=0, o_afull=0 (AFULL_LEVEL>0), o_overflow=0, o_drop_count=0.
REQ-034 i_data_vld and i_data_rdy SHALL be ignored in any cycle where i_clk_rst=1.
REQ-035 Reset mid-operation SHALL discard all stored words; the first push after reset SHALL be the first word output.

Verification
REQ-036 Reset, then push 0x11,0x22,0x33 on consecutive cycles with i_data_rdy=1 -> o_data 0x11,0x22,0x33 starting one cycle after the first push; o_level never exceeds 1.
REQ-037 i_data_rdy=0, push 16 words 0..15 (DEPTH=16) -> o_level=16, o_afull=1 from level 12, o_data=0 held stable; o_overflow=0.
REQ-038 Full buffer, push 3 more words, rdy=0 -> o_overflow=1, o_drop_count=3; then drain -> output 0..15 only.
REQ-039 Full buffer, rdy=1 and push the same cycle -> no drop, o_level stays 16, the new word emerges after the 16 stored words.
REQ-040 o_drop_count=5, assert i_clr_overflow in the same cycle as a drop -> o_overflow=1, o_drop_count=1; clear alone -> 0/0.
REQ-041 Assert reset with 7 stored words -> o_data_vld=0, o_level=0 next cycle; push 0xAB -> 0xAB is the next word output.
